// File: rtl/led_pkg.sv
// Shared parameters and types for the LED PWM driver.
package led_pkg;

    localparam int NUM_LED  = 5;
    localparam int DUTY_W   = 8;
    localparam int IDX_W    = 3;
    localparam int PRESCALE = 47;

    typedef logic [DUTY_W-1:0] duty_t;

    localparam duty_t LED_MAX = duty_t'((1 << DUTY_W) - 1);

    // Number of phase steps in one PWM period for a given duty width.
    function automatic int period_steps(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaled phase counter for the PWM period; phase steps 0..MAX-1, wrap marks the last step.
// Holds its count while en is low; tick and wrap are combinational from the current count.
module pwm_timebase #(
    parameter int DUTY_W   = 8,
    parameter int PRESCALE = 47
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [DUTY_W-1:0] phase,
    output logic              tick,
    output logic              wrap
);
    import led_pkg::*;

    localparam int CNT_W = $clog2(PRESCALE) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(PRESCALE - 1);
    localparam logic [DUTY_W-1:0] PHASE_LAST = DUTY_W'(period_steps(DUTY_W) - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == CNT_LAST);
    assign wrap = tick && (phase == PHASE_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            phase <= '0;
        end else if (tick) begin
            cnt   <= '0;
            phase <= wrap ? '0 : phase + 1'b1;
        end else if (en) begin
            cnt   <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_pwm_driver.sv
// Per-LED PWM brightness with shadow registers that apply only at a period boundary.
// Write port is always ready after reset; shadow to active copy happens on phase wrap.
module led_pwm_driver #(
    parameter int NUM_LED  = led_pkg::NUM_LED,
    parameter int DUTY_W   = led_pkg::DUTY_W,
    parameter int PRESCALE = led_pkg::PRESCALE,
    parameter int IDX_W    = led_pkg::IDX_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [DUTY_W-1:0]  wr_duty,
    output logic [NUM_LED-1:0] led,
    output logic               period_start,
    output logic               update_pending
);
    import led_pkg::*;

    logic [DUTY_W-1:0] shadow [NUM_LED];
    logic [DUTY_W-1:0] active [NUM_LED];
    logic [DUTY_W-1:0] phase;
    logic              tick;
    logic              wrap;
    logic              load;
    logic              accept;
    logic              idx_ok;
    logic              wr_hit;

    pwm_timebase #(
        .DUTY_W   (DUTY_W),
        .PRESCALE (PRESCALE)
    ) u_timebase (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .phase (phase),
        .tick  (tick),
        .wrap  (wrap)
    );

    assign load   = tick && wrap;
    assign accept = wr_valid && wr_ready;
    assign idx_ok = ({1'b0, wr_idx} < (IDX_W+1)'(NUM_LED));
    assign wr_hit = accept && idx_ok;

    // Active loads sample the pre-write shadow, so a write on the wrap edge waits a period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_LED; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
                led[i]    <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_LED; i++) begin
                if (wr_hit && (wr_idx == IDX_W'(i)))
                    shadow[i] <= wr_duty;
                if (load)
                    active[i] <= shadow[i];
                led[i] <= en && (phase < active[i]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ready       <= 1'b0;
            period_start   <= 1'b0;
            update_pending <= 1'b0;
        end else begin
            wr_ready     <= 1'b1;
            period_start <= load;
            if (wr_hit)
                update_pending <= 1'b1;
            else if (load)
                update_pending <= 1'b0;
        end
    end

endmodule

// File: tb/tb_led_pwm_driver.sv
// Scoreboarded bench for led_pwm_driver with DUTY_W=4, PRESCALE=2, NUM_LED=5.
module tb_led_pwm_driver;

    localparam int NL  = 5;
    localparam int DW  = 4;
    localparam int PS  = 2;
    localparam int IW  = 3;
    localparam int MX  = 15;
    localparam int PER = MX * PS;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          wr_valid;
    logic          wr_ready;
    logic [IW-1:0] wr_idx;
    logic [DW-1:0] wr_duty;
    logic [NL-1:0] led;
    logic          period_start;
    logic          update_pending;

    led_pwm_driver #(
        .NUM_LED  (NL),
        .DUTY_W   (DW),
        .PRESCALE (PS),
        .IDX_W    (IW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_idx         (wr_idx),
        .wr_duty        (wr_duty),
        .led            (led),
        .period_start   (period_start),
        .update_pending (update_pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NL-1:0] led;
        logic          ps;
        logic          pend;
        logic          rdy;
    } exp_t;

    exp_t exp_q [$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    // Reference model: behaviour described at the level of "what the LEDs must do".
    int m_cnt = 0;
    int m_phase = 0;
    int m_shadow [NL];
    int m_active [NL];
    logic m_pend = 1'b0;
    logic m_rdy = 1'b0;

    task automatic model_step();
        exp_t e;
        bit   step_now;
        bit   period_end;
        if (rst) begin
            m_cnt = 0;
            m_phase = 0;
            m_pend = 1'b0;
            m_rdy = 1'b0;
            for (int i = 0; i < NL; i++) begin
                m_shadow[i] = 0;
                m_active[i] = 0;
            end
            exp_q.delete();
        end else begin
            step_now   = en && (m_cnt == PS - 1);
            period_end = step_now && (m_phase == MX - 1);
            for (int i = 0; i < NL; i++)
                e.led[i] = en && (m_phase < m_active[i]);
            e.ps = period_end;
            if (period_end)
                for (int i = 0; i < NL; i++)
                    m_active[i] = m_shadow[i];
            if (wr_valid && m_rdy && (int'(wr_idx) < NL)) begin
                m_shadow[int'(wr_idx)] = int'(wr_duty);
                m_pend = 1'b1;
            end else if (period_end) begin
                m_pend = 1'b0;
            end
            if (step_now) begin
                m_cnt = 0;
                m_phase = period_end ? 0 : m_phase + 1;
            end else if (en) begin
                m_cnt = m_cnt + 1;
            end
            m_rdy = 1'b1;
            e.pend = m_pend;
            e.rdy = m_rdy;
            exp_q.push_back(e);
        end
    endtask

    for (genvar g = 0; g < NL; g++) begin : g_init
        initial begin
            m_shadow[g] = 0;
            m_active[g] = 0;
        end
    end

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_led",  32'(led),            32'(e.led));
            chk("sb_ps",   32'(period_start),   32'(e.ps));
            chk("sb_pend", 32'(update_pending), 32'(e.pend));
            chk("sb_rdy",  32'(wr_ready),       32'(e.rdy));
        end
    end

    task automatic wait_ps(input string tag, output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!period_start && waited < 4 * PER);
        if (!period_start)
            chk({tag, "_timeout"}, 32'(0), 32'(1));
    endtask

    // Counts on-cycles per LED over one full period starting at a period_start negedge.
    task automatic count_period(input string tag, output int cnt [NL]);
        for (int i = 0; i < NL; i++) cnt[i] = 0;
        for (int k = 0; k < PER; k++) begin
            @(negedge clk);
            for (int i = 0; i < NL; i++) cnt[i] += int'(led[i]);
        end
        chk({tag, "_ps_at_end"}, 32'(period_start), 32'(1));
    endtask

    task automatic write(input int idx, input int duty);
        wr_valid = 1'b1;
        wr_idx   = IW'(idx);
        wr_duty  = DW'(duty);
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    initial begin
        int w;
        int c [NL];
        int on4;
        rst = 1'b1; en = 1'b1; wr_valid = 1'b0; wr_idx = '0; wr_duty = '0;
        repeat (3) @(negedge clk);
        chk("rst_led",  32'(led),            32'(0));
        chk("rst_rdy",  32'(wr_ready),       32'(0));
        chk("rst_pend", 32'(update_pending), 32'(0));
        rst = 1'b0;

        // 1: first period boundary 30 clocks after release
        wait_ps("t1", w);
        chk("t1_first_ps_clks", 32'(w), 32'(PER));
        chk("t1_led", 32'(led), 32'(0));

        // 2: mid-period writes apply only at the next boundary
        repeat (5) @(negedge clk);
        write(0, 15); write(1, 0); write(2, 5);
        chk("t2_pend", 32'(update_pending), 32'(1));
        chk("t2_led_held", 32'(led), 32'(0));
        wait_ps("t2", w);
        chk("t2_pend_clr", 32'(update_pending), 32'(0));
        count_period("t2", c);
        chk("t2_on0", 32'(c[0]), 32'(30));
        chk("t2_on1", 32'(c[1]), 32'(0));
        chk("t2_on2", 32'(c[2]), 32'(10));

        // 3: write on the exact wrap edge
        repeat (PER - 1) @(negedge clk);
        wr_valid = 1'b1; wr_idx = 3'd3; wr_duty = 4'd7;
        @(negedge clk);
        wr_valid = 1'b0;
        chk("t3_ps", 32'(period_start), 32'(1));
        chk("t3_pend_kept", 32'(update_pending), 32'(1));
        count_period("t3a", c);
        chk("t3_on3_old", 32'(c[3]), 32'(0));
        chk("t3_pend_clr", 32'(update_pending), 32'(0));
        count_period("t3b", c);
        chk("t3_on3_new", 32'(c[3]), 32'(14));

        // 4: out-of-range index is accepted and dropped
        repeat (4) @(negedge clk);
        chk("t4_rdy", 32'(wr_ready), 32'(1));
        write(6, 9);
        chk("t4_pend", 32'(update_pending), 32'(0));
        wait_ps("t4", w);
        count_period("t4", c);
        chk("t4_on0", 32'(c[0]), 32'(30));
        chk("t4_on2", 32'(c[2]), 32'(10));
        chk("t4_on3", 32'(c[3]), 32'(14));
        chk("t4_on4", 32'(c[4]), 32'(0));

        // 5: en dropped at phase 3 for 20 clocks on a duty-8 channel
        write(4, 8);
        wait_ps("t5", w);
        on4 = 0;
        w = 0;
        do begin
            @(negedge clk);
            w++;
            on4 += int'(led[4]);
            if (w == 7) en = 1'b0;
            if (w == 8) chk("t5_led_off", 32'(led), 32'(0));
            if (w == 27) en = 1'b1;
        end while (!period_start && w < 4 * PER);
        chk("t5_period_clks", 32'(w), 32'(PER + 20));
        chk("t5_on4_total", 32'(on4), 32'(16));

        // 6: reset in the middle of a lit period
        repeat (19) @(negedge clk);
        chk("t6_led_lit", 32'(led), 32'(5'b00001));
        #2 rst = 1'b1;
        #1;
        chk("t6_led_async", 32'(led), 32'(0));
        chk("t6_rdy_async", 32'(wr_ready), 32'(0));
        chk("t6_pend_async", 32'(update_pending), 32'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_ps("t6", w);
        chk("t6_ps_clks", 32'(w), 32'(PER));
        count_period("t6", c);
        for (int i = 0; i < NL; i++)
            chk($sformatf("t6_on%0d", i), 32'(c[i]), 32'(0));

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
